// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: periodic trigger, synchronised echo capture and pulse-width
// to centimetre conversion, saturating at 100 (reported as 99 + Out_Of_Range).
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned CYCLES_PER_CM = 2900,
    parameter int unsigned PERIOD_CYCLES = 3_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Enable,
    input  logic       Echo,
    output logic       Trig,
    output logic [6:0] Distance_Raw,
    output logic       Distance_Valid,
    output logic       Out_Of_Range
);

    localparam int unsigned TW  = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned PSW = $clog2(CYCLES_PER_CM + 1);
    localparam int unsigned PW  = $clog2(PERIOD_CYCLES + 1);

    localparam logic [TW-1:0]  TRIG_LAST   = TW'(TRIG_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST     = PSW'(CYCLES_PER_CM - 1);
    localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLD
    } state_t;

    state_t         r_state;
    logic           r_echo_m;
    logic           r_echo_s;
    logic           r_echo_d;
    logic [TW-1:0]  r_trig_cnt;
    logic [PSW-1:0] r_prescale;
    logic [PW-1:0]  r_period;
    logic [6:0]     r_cm;
    logic           r_trig;
    logic [6:0]     r_dist;
    logic           r_valid;
    logic           r_oor;

    logic       w_rise;
    logic       w_fall;
    logic       w_period_end;
    logic       w_ps_wrap;
    logic [6:0] w_cm_next;

    assign w_rise       = r_echo_s & ~r_echo_d;
    assign w_fall       = ~r_echo_s & r_echo_d;
    assign w_period_end = (r_period == PERIOD_LAST);
    assign w_ps_wrap    = (r_prescale == PS_LAST);

    // Counting on the delayed echo copy covers exactly the echo_s-high cycles, the
    // last of which coincides with the falling-edge cycle, so the publish uses this.
    always_comb begin
        w_cm_next = r_cm;
        if (r_echo_d && w_ps_wrap && (r_cm != 7'd100)) begin
            w_cm_next = r_cm + 7'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_echo_m   <= 1'b0;
            r_echo_s   <= 1'b0;
            r_echo_d   <= 1'b0;
            r_trig_cnt <= '0;
            r_prescale <= '0;
            r_period   <= '0;
            r_cm       <= '0;
            r_trig     <= 1'b0;
            r_dist     <= '0;
            r_valid    <= 1'b0;
            r_oor      <= 1'b0;
        end else begin
            r_echo_m <= Echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;
            r_valid  <= 1'b0;
            if (!w_period_end) begin
                r_period <= r_period + PW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (Enable) begin
                        r_state    <= S_TRIG;
                        r_trig     <= 1'b1;
                        r_trig_cnt <= '0;
                        r_period   <= '0;
                    end
                end
                S_TRIG: begin
                    if (r_trig_cnt == TRIG_LAST) begin
                        r_trig  <= 1'b0;
                        r_state <= S_WAIT_ECHO;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + TW'(1);
                    end
                end
                S_WAIT_ECHO: begin
                    if (w_rise) begin
                        r_prescale <= '0;
                        r_cm       <= '0;
                        r_state    <= S_MEASURE;
                    end else if (w_period_end) begin
                        r_dist     <= 7'd99;
                        r_oor      <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= Enable ? S_TRIG : S_IDLE;
                        r_trig     <= Enable;
                        r_trig_cnt <= '0;
                        r_period   <= '0;
                    end
                end
                S_MEASURE: begin
                    if (r_echo_d) begin
                        r_prescale <= w_ps_wrap ? '0 : r_prescale + PSW'(1);
                        r_cm       <= w_cm_next;
                    end
                    if (w_fall) begin
                        r_dist  <= (w_cm_next == 7'd100) ? 7'd99 : w_cm_next;
                        r_oor   <= (w_cm_next == 7'd100);
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else if (w_period_end) begin
                        r_dist     <= 7'd99;
                        r_oor      <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= Enable ? S_TRIG : S_IDLE;
                        r_trig     <= Enable;
                        r_trig_cnt <= '0;
                        r_period   <= '0;
                    end
                end
                S_HOLD: begin
                    if (w_period_end) begin
                        r_state    <= Enable ? S_TRIG : S_IDLE;
                        r_trig     <= Enable;
                        r_trig_cnt <= '0;
                        r_period   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    assign Trig           = r_trig;
    assign Distance_Raw   = r_dist;
    assign Distance_Valid = r_valid;
    assign Out_Of_Range   = r_oor;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed and randomised checks of ultrasonic_ranger against an arithmetic distance model.
module tb_ultrasonic_ranger;

    localparam int TRIG = 5;
    localparam int CPM  = 4;
    localparam int PER  = 1000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       Enable = 1'b0;
    logic       Echo = 1'b0;
    logic       Trig;
    logic [6:0] Distance_Raw;
    logic       Distance_Valid;
    logic       Out_Of_Range;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int rise_q[$];
    logic trig_prev = 1'b0;

    ultrasonic_ranger #(
        .TRIG_CYCLES  (TRIG),
        .CYCLES_PER_CM(CPM),
        .PERIOD_CYCLES(PER)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Enable        (Enable),
        .Echo          (Echo),
        .Trig          (Trig),
        .Distance_Raw  (Distance_Raw),
        .Distance_Valid(Distance_Valid),
        .Out_Of_Range  (Out_Of_Range)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Distance_Valid) valid_cnt++;
        if (Trig && !trig_prev) rise_q.push_back(cyc);
        trig_prev = Trig;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: whole centimetres, saturating at 100, shown as 99 with the range flag.
    function automatic int model_cm(input int n);
        int cm;
        cm = n / CPM;
        if (cm > 100) cm = 100;
        return cm;
    endfunction

    task automatic wait_valid(input int budget, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!Distance_Valid && k < budget);
        chk("valid_seen", Distance_Valid, 1);
    endtask

    task automatic wait_trig_fall();
        int k;
        k = 0;
        while (!Trig && k < 2000) begin tick(); k++; end
        while (Trig && k < 2000) begin tick(); k++; end
        chk("trig_cycle_timeout", (k < 2000), 1);
    endtask

    task automatic do_echo(input string tag, input int n);
        int k;
        int cm;
        Echo = 1'b1;
        repeat (n) tick();
        Echo = 1'b0;
        wait_valid(20, k);
        cm = model_cm(n);
        chk({tag, "_latency"}, k, 3);
        chk({tag, "_raw"}, Distance_Raw, (cm == 100) ? 99 : cm);
        chk({tag, "_oor"}, Out_Of_Range, (cm == 100));
        tick();
        chk({tag, "_pulse1"}, Distance_Valid, 0);
    endtask

    task automatic measure(input string tag, input int n, input int pre);
        wait_trig_fall();
        repeat (pre) tick();
        do_echo(tag, n);
    endtask

    initial begin
        int w;
        int k;
        int n;
        int saved;
        int rises;

        // Reset state
        repeat (3) tick();
        chk("rst_trig", Trig, 0);
        chk("rst_raw", Distance_Raw, 0);
        chk("rst_valid", Distance_Valid, 0);
        chk("rst_oor", Out_Of_Range, 0);

        RESET = 1'b0;
        tick();
        Enable = 1'b1;
        tick();
        chk("trig_rise_latency", Trig, 1);
        w = 0;
        while (Trig && w < 100) begin w++; tick(); end
        chk("trig_width", w, TRIG);

        repeat (4) tick();
        do_echo("echo40", 40);

        wait_trig_fall();
        chk("trig_rises", rise_q.size(), 2);
        if (rise_q.size() >= 2) chk("trig_spacing", rise_q[1] - rise_q[0], PER);
        repeat (2) tick();
        do_echo("echo3", 3);

        measure("echo399", 399, 3);
        measure("echo400", 400, 7);
        measure("echo401", 401, 2);

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 420);
            measure($sformatf("rand%0d_n%0d", i, n), n, $urandom_range(1, 30));
        end

        measure("echo40b", 40, 5);

        // No echo: abort at period end, next trigger on the same edge
        wait_trig_fall();
        wait_valid(1100, k);
        chk("noecho_latency", k, PER - TRIG);
        chk("noecho_raw", Distance_Raw, 99);
        chk("noecho_oor", Out_Of_Range, 1);
        chk("noecho_next_trig", Trig, 1);

        // Echo high before WAIT_ECHO and across the whole period
        Echo = 1'b1;
        wait_valid(1100, k);
        chk("stuck_latency", k, PER);
        chk("stuck_raw", Distance_Raw, 99);
        chk("stuck_oor", Out_Of_Range, 1);
        chk("stuck_next_trig", Trig, 1);

        // Echo still high on WAIT_ECHO entry: only the later rise counts
        wait_trig_fall();
        repeat (10) tick();
        Echo = 1'b0;
        repeat (5) tick();
        do_echo("prehigh40", 40);

        // Enable dropped mid-measurement
        wait_trig_fall();
        repeat (3) tick();
        Echo = 1'b1;
        repeat (10) tick();
        Enable = 1'b0;
        repeat (30) tick();
        Echo = 1'b0;
        wait_valid(20, k);
        chk("endrop_latency", k, 3);
        chk("endrop_raw", Distance_Raw, 10);
        chk("endrop_oor", Out_Of_Range, 0);
        rises = rise_q.size();
        repeat (1200) tick();
        chk("endrop_no_trig", rise_q.size(), rises);
        chk("endrop_trig_low", Trig, 0);

        Enable = 1'b1;
        tick();
        chk("reenable_trig", Trig, 1);

        // Reset mid-measurement
        wait_trig_fall();
        Echo = 1'b1;
        repeat (20) tick();
        saved = valid_cnt;
        RESET = 1'b1;
        Enable = 1'b0;
        tick();
        chk("midrst_trig", Trig, 0);
        chk("midrst_raw", Distance_Raw, 0);
        chk("midrst_valid", Distance_Valid, 0);
        chk("midrst_oor", Out_Of_Range, 0);
        Echo = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;
        repeat (30) tick();
        chk("midrst_no_valid", valid_cnt, saved);
        chk("midrst_idle_trig", Trig, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
